// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer state encoding and the bit-reverse
// address helper used by both the core and the output sequencer.
package fft_pkg;

  localparam int unsigned ST_W      = 3;
  localparam int unsigned MAX_LOG2N = 10;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_RD   = 3'd1;
  localparam logic [ST_W-1:0] ST_LAT  = 3'd2;
  localparam logic [ST_W-1:0] ST_WLOW = 3'd3;
  localparam logic [ST_W-1:0] ST_PRES = 3'd4;
  localparam logic [ST_W-1:0] ST_REL  = 3'd5;
  localparam logic [ST_W-1:0] ST_DONE = 3'd6;

  typedef enum logic [ST_W-1:0] {
    S_IDLE = ST_IDLE,
    S_RD   = ST_RD,
    S_LAT  = ST_LAT,
    S_WLOW = ST_WLOW,
    S_PRES = ST_PRES,
    S_REL  = ST_REL,
    S_DONE = ST_DONE
  } seq_state_t;

  // Reverse the low log2n bits of idx; upper result bits are zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                  input int unsigned log2n);
    logic [MAX_LOG2N-1:0] r;
    for (int i = 0; i < MAX_LOG2N; i++) r[i] = idx[MAX_LOG2N-1-i];
    return r >> (MAX_LOG2N - log2n);
  endfunction

endpackage

// File: rtl/fft_out_sequencer_sync2.sv
// Two-flop synchroniser for the sink acknowledge; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fft_out_sequencer.sv
// Drains one FFT result frame from the result RAM to a serial sink using a
// four-phase req/ans handshake per sample, natural or bit-reversed order.
module fft_out_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N  = 4,
  parameter int unsigned DW     = 16,
  parameter bit          BITREV = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             mem_rd,
  output logic [LOG2N-1:0] mem_addr,
  input  logic [DW-1:0]    mem_dR,
  input  logic [DW-1:0]    mem_dJ,
  output logic             out_en,
  output logic [DW-1:0]    data_oR,
  output logic [DW-1:0]    data_oJ,
  output logic             req_o,
  input  logic             ans_i,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] idx
);

  localparam logic [LOG2N-1:0] IDX_LAST = '1;

  seq_state_t       state, state_n;
  logic [LOG2N-1:0] idx_n;
  logic             ans_s;

  function automatic logic [LOG2N-1:0] addr_of(input logic [LOG2N-1:0] i);
    if (BITREV) return LOG2N'(bitrev(MAX_LOG2N'(i), LOG2N));
    return i;
  endfunction

  sync2 u_sync_ans (
    .clk (clk),
    .rst (rst),
    .d   (ans_i),
    .q   (ans_s)
  );

  // Next-state and index update; abort overrides everything, including start.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE: if (start) begin
        idx_n   = '0;
        state_n = S_RD;
      end
      S_RD:   state_n = S_LAT;
      S_LAT:  state_n = S_WLOW;
      S_WLOW: if (!ans_s) state_n = S_PRES;
      S_PRES: if (ans_s) state_n = S_REL;
      S_REL:  if (!ans_s) begin
        if (idx == IDX_LAST) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + LOG2N'(1);
          state_n = S_RD;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n = S_IDLE;
      idx_n   = idx;
    end
  end

  // Outputs are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      out_en   <= 1'b0;
      req_o    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_oR  <= '0;
      data_oJ  <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      mem_rd   <= (state_n == S_RD);
      mem_addr <= addr_of(idx_n);
      out_en   <= (state_n == S_LAT);
      req_o    <= (state_n == S_PRES);
      busy     <= (state_n != S_IDLE);
      done     <= (state_n == S_DONE);
      // RAM data is valid during LAT; hold it until the next sample's LAT.
      if (state == S_LAT) begin
        data_oR <= mem_dR;
        data_oJ <= mem_dJ;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_sequencer.sv
// Self-checking bench for fft_out_sequencer: control vector table plus
// scoreboarded frames (instant sink, slow sink, stale ack, abort).
module tb_fft_out_sequencer;

  localparam int unsigned LOG2N = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned N     = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             ans_i = 1'b0;
  logic             mem_rd, out_en, req_o, busy, done;
  logic [LOG2N-1:0] mem_addr, idx;
  logic [DW-1:0]    mem_dR = '0;
  logic [DW-1:0]    mem_dJ = '0;
  logic [DW-1:0]    data_oR, data_oJ;

  always #5 clk = ~clk;

  fft_out_sequencer #(.LOG2N(LOG2N), .DW(DW), .BITREV(1'b1)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_dR   (mem_dR),
    .mem_dJ   (mem_dJ),
    .out_en   (out_en),
    .data_oR  (data_oR),
    .data_oJ  (data_oJ),
    .req_o    (req_o),
    .ans_i    (ans_i),
    .busy     (busy),
    .done     (done),
    .idx      (idx)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM model: RAM[a] = a (real), a ^ A5A5 (imag), one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_dR <= 16'(mem_addr);
      mem_dJ <= 16'(mem_addr) ^ 16'hA5A5;
    end
  end

  // Reference view of the synchronised ack.
  logic tb_s1 = 1'b0;
  logic tb_s2 = 1'b0;
  always @(posedge clk) begin
    tb_s1 <= ans_i;
    tb_s2 <= tb_s1;
  end

  // Sink: 0 manual, 1 instant ack, 2 slow (ack 5 cycles after req, release 3 after drop).
  int sink_mode = 0;
  int hi_cnt = 0;
  int lo_cnt = 0;
  always @(negedge clk) begin
    if (sink_mode == 1) begin
      ans_i = req_o;
    end else if (sink_mode == 2) begin
      if (req_o) begin
        lo_cnt = 0;
        if (hi_cnt >= 4) ans_i = 1'b1;
        else hi_cnt++;
      end else begin
        hi_cnt = 0;
        if (ans_i) begin
          if (lo_cnt >= 2) ans_i = 1'b0;
          else lo_cnt++;
        end
      end
    end
  end

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] j;
    logic [3:0]  k;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  bit          sb_on = 1'b0;
  logic        req_prev = 1'b0;
  logic        s_prev = 1'b0;
  logic [15:0] held_r = '0;
  logic [15:0] held_j = '0;
  int          out_en_cnt = 0;
  int          done_cnt = 0;

  // Scoreboard monitor: pop on each req_o rise, check hold while req_o stays high.
  always @(negedge clk) begin
    if (sb_on) begin
      if (out_en) out_en_cnt++;
      if (done) done_cnt++;
      if (req_o && !req_prev) begin
        check("req_rise_ans_low", 64'(s_prev), 64'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: req_o rose at idx %0d with no expected sample", idx);
        end else begin
          sb_e = sb_q.pop_front();
          check("sample_r", 64'(data_oR), 64'(sb_e.r));
          check("sample_j", 64'(data_oJ), 64'(sb_e.j));
          check("sample_idx", 64'(idx), 64'(sb_e.k));
        end
        held_r = data_oR;
        held_j = data_oJ;
      end else if (req_o) begin
        check("hold_r", 64'(data_oR), 64'(held_r));
        check("hold_j", 64'(data_oJ), 64'(held_j));
      end
    end
    req_prev = req_o;
    s_prev   = tb_s2;
  end

  task automatic push_frame();
    logic [3:0] kk, a;
    for (int k = 0; k < int'(N); k++) begin
      kk = 4'(k);
      a  = {kk[0], kk[1], kk[2], kk[3]};
      sb_q.push_back('{r: 16'(a), j: 16'(a) ^ 16'hA5A5, k: kk});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done; optionally injects stray start pulses while busy.
  task automatic wait_done(input int budget, input bit noise);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
        check("busy_with_done", 64'(busy), 64'd1);
      end else begin
        start = noise && (n % 37 == 5);
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: no done within %0d cycles", budget);
    end else begin
      @(negedge clk);
      check("busy_after_done", 64'(busy), 64'd0);
      check("done_width", 64'(done), 64'd0);
    end
  endtask

  task automatic run_frame(input int mode, input bit noise);
    sink_mode  = mode;
    out_en_cnt = 0;
    done_cnt   = 0;
    push_frame();
    pulse_start();
    wait_done(3000, noise);
    check("done_count", 64'(done_cnt), 64'd1);
    check("out_en_count", 64'(out_en_cnt), 64'(N));
    check("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  typedef struct {
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  flags;  // {busy, req_o, mem_rd, out_en, done}
    logic [15:0] dj;
  } vec_t;

  vec_t tbl[12];

  initial begin
    bit found;
    int n;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 16'h0000};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 5'b00000, 16'h0000};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 5'b10100, 16'h0000};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 5'b10010, 16'h0000};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'b10000, 16'hA5A5};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'b11000, 16'hA5A5};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 5'b00000, 16'hA5A5};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 5'b00000, 16'hA5A5};

    // Reset, start/abort priority and the first few states of a frame.
    for (int i = 0; i < 12; i++) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      abort = tbl[i].abort;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            64'({busy, req_o, mem_rd, out_en, done, mem_addr, idx, data_oR, data_oJ}),
            64'({tbl[i].flags, 4'h0, 4'h0, 16'h0000, tbl[i].dj}));
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (4) @(negedge clk);

    sb_on = 1'b1;

    // Bit-reversed frame with an instant sink.
    run_frame(1, 1'b0);

    // Slow sink with stray starts while busy.
    run_frame(2, 1'b1);
    repeat (6) @(negedge clk);

    // Stale ack held high at frame start.
    sink_mode = 0;
    ans_i = 1'b1;
    repeat (4) @(negedge clk);
    push_frame();
    out_en_cnt = 0;
    done_cnt   = 0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stale_req", 64'(req_o), 64'd0);
      check("stale_busy", 64'(busy), 64'd1);
    end
    ans_i = 1'b0;
    sink_mode = 1;
    @(negedge clk);
    check("stale_rel1", 64'(req_o), 64'd0);
    @(negedge clk);
    check("stale_rel2", 64'(req_o), 64'd0);
    @(negedge clk);
    check("stale_rel3", 64'(req_o), 64'd1);
    wait_done(1000, 1'b0);
    check("stale_done_count", 64'(done_cnt), 64'd1);
    check("stale_out_en_count", 64'(out_en_cnt), 64'(N));
    repeat (4) @(negedge clk);

    // Abort in PRES at idx 5, then a clean frame.
    sink_mode = 1;
    push_frame();
    out_en_cnt = 0;
    done_cnt   = 0;
    pulse_start();
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      @(negedge clk);
      n++;
      if (req_o && idx == 4'd5) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL abort_reach: PRES at idx 5 not reached within 500 cycles");
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 64'({busy, req_o, mem_rd, out_en, done}), 64'd0);
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    sb_q.delete();
    run_frame(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
